// File: rtl/nsub_pkg.sv
// rtl/nsub_pkg.sv - shared types and helpers for the nibble-serial subtractor
package nsub_pkg;

  typedef enum logic {S_IDLE, S_SUB} state_t;

  localparam int NIBBLE_W = 4;

  // Width of the nibble index; a single-nibble build still needs one bit.
  function automatic int cnt_width(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/sub4_borrow.sv
// rtl/sub4_borrow.sv - combinational 4-bit subtract slice with borrow in/out
module sub4_borrow (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       BI,
  output logic [3:0] D,
  output logic       BO
);

  logic [4:0] w_diff;

  // A 5-bit difference puts the borrow in the top bit when it wraps below zero.
  assign w_diff = {1'b0, A} - {1'b0, B} - {4'b0000, BI};
  assign D      = w_diff[3:0];
  assign BO     = w_diff[4];

endmodule

// File: rtl/nibble_serial_sub.sv
// rtl/nibble_serial_sub.sv - nibble-serial A-B-BI subtractor; optional Z/N flags under NSUB_FLAGS_EN
module nibble_serial_sub
  import nsub_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = NIBBLE_W * NIBBLES
) (
  input  logic         CLK,
  input  logic         RESETL,
  input  logic         START,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         BI,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] D,
`ifdef NSUB_FLAGS_EN
  output logic         Z,
  output logic         N,
`endif
  output logic         BO
);

  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_ar;
  logic [W-1:0]    r_bb;
  logic [W-1:0]    r_d;
  logic            r_br;
  logic            r_busy;
  logic            r_done;
  logic            r_bo;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_d_nib;
  logic            w_bo_nib;
  logic            w_accept;
  logic            w_last;

  assign w_accept = (r_state == S_IDLE) && START;
  assign w_last   = (r_state == S_SUB) && (r_cnt == LAST);
  assign w_a_nib  = r_ar[r_cnt * NIBBLE_W +: NIBBLE_W];
  assign w_b_nib  = r_bb[r_cnt * NIBBLE_W +: NIBBLE_W];

  sub4_borrow u_slice (
    .A  (w_a_nib),
    .B  (w_b_nib),
    .BI (r_br),
    .D  (w_d_nib),
    .BO (w_bo_nib)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: leave idle on a start, return after the top nibble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START)  w_state_nxt = S_SUB;
      S_SUB:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, nibble walk, borrow chain and result assembly.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_cnt  <= '0;
      r_ar   <= '0;
      r_bb   <= '0;
      r_d    <= '0;
      r_br   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_bo   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_ar   <= A;
        r_bb   <= B;
        r_br   <= BI;
        r_cnt  <= '0;
        r_d    <= '0;
        r_busy <= 1'b1;
      end else if (r_state == S_SUB) begin
        r_d[r_cnt * NIBBLE_W +: NIBBLE_W] <= w_d_nib;
        r_br <= w_bo_nib;
        if (w_last) begin
          r_done <= 1'b1;
          r_bo   <= w_bo_nib;
          r_busy <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

`ifdef NSUB_FLAGS_EN
  logic r_zacc;
  logic r_z;
  logic r_n;

  // Zero-ness is folded in one nibble at a time so no wide compare is needed.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_zacc <= 1'b1;
      r_z    <= 1'b1;
      r_n    <= 1'b0;
    end else if (w_accept) begin
      r_zacc <= 1'b1;
    end else if (r_state == S_SUB) begin
      r_zacc <= r_zacc & (w_d_nib == 4'h0);
      if (w_last) begin
        r_z <= r_zacc & (w_d_nib == 4'h0);
        r_n <= w_d_nib[3];
      end
    end
  end

  assign Z = r_z;
  assign N = r_n;
`endif

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign D    = r_d;
  assign BO   = r_bo;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb/tb_nibble_serial_sub.sv - scoreboard bench for nibble_serial_sub
module tb_nibble_serial_sub;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         CLK = 1'b0;
  logic         RESETL = 1'b0;
  logic         START = 1'b0;
  logic         BI = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY;
  logic         DONE;
  logic         BO;
  logic [W-1:0] D;
`ifdef NSUB_FLAGS_EN
  logic         Z;
  logic         N;
`endif

  nibble_serial_sub #(.NIBBLES(NIBBLES)) dut (
    .CLK    (CLK),
    .RESETL (RESETL),
    .START  (START),
    .A      (A),
    .B      (B),
    .BI     (BI),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .D      (D),
`ifdef NSUB_FLAGS_EN
    .Z      (Z),
    .N      (N),
`endif
    .BO     (BO)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         n;
    int           due;
  } exp_t;

  exp_t sb[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned arithmetic on the whole operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi, input int due);
    exp_t e;
    longint unsigned ua, sub;
    ua    = longint'(a);
    sub   = longint'(b) + longint'(bi);
    e.d   = W'(ua - sub);
    e.bo  = (ua < sub);
    e.z   = (e.d == '0);
    e.n   = e.d[W-1];
    e.due = due;
    return e;
  endfunction

  // Called just after a falling edge; the next rising edge samples START.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input bit accept);
    A = a;
    B = b;
    BI = bi;
    START = 1'b1;
    if (accept) sb.push_back(model(a, b, bi, cyc + 1 + NIBBLES));
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no DONE expected DONE within 40 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge CLK);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every DONE must match the oldest outstanding expectation, on time.
  always @(negedge CLK) begin
    if (RESETL) begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_done: got none expected DONE at cycle %0d", sb[0].due);
        void'(sb.pop_front());
      end
      if (DONE) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got DONE expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("D", 64'(D), 64'(e.d));
          chk("BO", 64'(BO), 64'(e.bo));
          chk("busy_at_done", 64'(BUSY), 64'd0);
`ifdef NSUB_FLAGS_EN
          chk("Z", 64'(Z), 64'(e.z));
          chk("N", 64'(N), 64'(e.n));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic rbi;

    repeat (2) @(negedge CLK);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_d", 64'(D), 64'd0);
    chk("rst_bo", 64'(BO), 64'd0);
`ifdef NSUB_FLAGS_EN
    chk("rst_z", 64'(Z), 64'd1);
    chk("rst_n", 64'(N), 64'd0);
`endif
    RESETL = 1'b1;
    @(negedge CLK);
    #1;

    start_op(16'h1234, 16'h0234, 1'b0, 1'b1);
    chk("busy_after_start", 64'(BUSY), 64'd1);
    drain();
    chk("busy_idle", 64'(BUSY), 64'd0);
    #1;
    start_op(16'h0000, 16'h0001, 1'b0, 1'b1);
    drain();
    #1;
    start_op(16'h8000, 16'h7FFF, 1'b1, 1'b1);
    drain();

    // START while busy, with different operands, must be ignored.
    #1;
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b1);
    start_op(16'hFFFF, 16'h1111, 1'b1, 1'b0);
    drain();
    repeat (8) @(negedge CLK);
    chk("d_held", 64'(D), 64'h00FE);
    chk("bo_held", 64'(BO), 64'd0);

    // Back-to-back: second START issued in the DONE cycle.
    #1;
    start_op(16'h1111, 16'h0111, 1'b0, 1'b1);
    wait_done();
    #1;
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    drain();

    // Reset mid-operation aborts with no DONE.
    #1;
    start_op(16'hABCD, 16'h1234, 1'b0, 1'b1);
    @(negedge CLK);
    #1;
    RESETL = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", 64'(BUSY), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    chk("abort_d", 64'(D), 64'd0);
    chk("abort_bo", 64'(BO), 64'd0);
    repeat (2) @(negedge CLK);
    RESETL = 1'b1;
    repeat (8) @(negedge CLK);
    chk("abort_idle_busy", 64'(BUSY), 64'd0);
    #1;
    start_op(16'h4321, 16'h1234, 1'b1, 1'b1);
    drain();

    // Randomized operations, mixing idle gaps and back-to-back starts.
    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: rb = ra;
        1: ra = '0;
        2: begin ra = '0; rb = '1; end
        default: ;
      endcase
      #1;
      start_op(ra, rb, rbi, 1'b1);
      wait_done();
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge CLK);
      end
    end
    drain();
    repeat (4) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
